wallace_mul_pipe: RTL and testbench
===================================

WALLACE_MUL_PIPE -- requirements
Module: wallace_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 12: operand width in bits, legal range 4..32.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 adds an output register after the final adder, 0 drives the result from the stage-2 adder.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have port x_in, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port y_in, input, WIDTH bits: multiplier.
REQ-009 SHALL have port sign_in, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port result_out, output, 2*WIDTH bits: product.

Function
REQ-013 SHALL complete a transfer on a port when its valid and ready are both high at a clock edge.
REQ-014 SHALL register x_in, y_in and sign_in in stage 1 on an input transfer.
REQ-015 SHALL reduce partial products with a Wallace tree of full and half adders into a carry-save pair and register that pair in stage 2.
REQ-016 SHALL add the carry-save pair with a 2*WIDTH-bit carry-propagate adder in stage 3; when OUT_REG=0, stage 3 SHALL be combinational.
REQ-017 SHALL have a fixed latency from input transfer to out_valid of 3 cycles with OUT_REG=1 and 2 cycles with OUT_REG=0.
REQ-018 SHALL form result_out as the product of the operands, each zero-extended (sign_in=0) or sign-extended (sign_in=1) to 2*WIDTH bits, taken modulo 2^(2*WIDTH).
REQ-019 SHALL attach a valid bit to each pipeline stage; the last stage's valid bit drives out_valid.
REQ-020 SHALL compute a single advance enable, true when out_valid is 0 or out_ready is 1; all stages, valid bits included, SHALL move only when it is true.
REQ-021 SHALL drive in_ready equal to the advance enable, combinationally from out_ready and the internal valid state.
REQ-022 SHALL hold result_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL keep pipeline bubbles as invalid stages while stalled; bubbles are not compressed.
REQ-024 SHALL accept one new input and retire one result in the same cycle with no throughput loss, giving 1 result per cycle sustained.
REQ-025 SHALL leave result_out don't-care while out_valid=0.

Reset
REQ-026 SHALL clear all stage valid bits and out_valid to 0 on rst, and SHALL clear result_out and data registers to 0.
REQ-027 SHALL discard all in-flight operations on rst asserted mid-operation, with no result emitted for them.
REQ-028 SHALL drive in_ready to 1 during and immediately after reset.

Configuration
REQ-029 SHALL, with macro WALLACE_SIGNED_EN defined, implement sign_in using Baugh-Wooley sign handling inside the tree.
REQ-030 SHALL, without WALLACE_SIGNED_EN, treat sign_in as ignored, build an unsigned-only tree with no sign-correction logic, and leave the port present.

Structure
REQ-031 SHALL place the WIDTH bounds, the stage-count constants and the latency function in shared package wallace_pkg.
REQ-032 SHALL put the combinational carry-save reduction in sub-module wallace_csa_tree, parameterised by WIDTH and built from the existing FullAdder and HalfAdder cells.
REQ-033 SHALL keep the pipeline registers, the handshake and the final adder in wallace_mul_pipe.

Verification
REQ-034 SHALL verify with WIDTH=12, OUT_REG=1 and sign_in=0 that x=0xFFF, y=0xFFF gives result 0xFFE001 with out_valid exactly 3 cycles after the input transfer.
REQ-035 SHALL verify with WIDTH=12 and sign_in=1 that x=0x800, y=0x800 gives 0x400000, and that x=0xFFF, y=0x001 gives 0xFFFFFF.
REQ-036 SHALL verify that back-to-back inputs on 20 consecutive cycles with out_ready=1 give 20 correct results on 20 consecutive cycles, in order.
REQ-037 SHALL verify that with out_ready=0, 4 offered inputs give 3 accepted and then in_ready=0, with the held result stable; raising out_ready then drains 3 results in order.
REQ-038 SHALL verify that rst pulsed 1 cycle with 2 operations in flight gives out_valid=0 on the next cycle, no stale results, and in_ready=1.
REQ-039 SHALL verify that a build without WALLACE_SIGNED_EN, given x=0xFFF, y=0x001, sign_in=1, gives 0x000FFF.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared constants and elaboration helpers for the Wallace multiplier pipeline.
// Macro WALLACE_SIGNED_EN selects the Baugh-Wooley signed tree.
package wallace_pkg;
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;
  localparam int STG_IN    = 1;
  localparam int STG_CSA   = 2;
  localparam int STG_OUT   = 3;

`ifdef WALLACE_SIGNED_EN
  localparam bit SIGNED_TREE = 1'b1;
`else
  localparam bit SIGNED_TREE = 1'b0;
`endif

  function automatic int latency(input int out_reg);
    return (out_reg != 0) ? STG_OUT : STG_CSA;
  endfunction

  // Signed tree works on operands extended by one bit, so zero- and
  // sign-extension both become plain Baugh-Wooley on WIDTH+1 bits.
  function automatic int tree_bits(input int w);
    return SIGNED_TREE ? w + 1 : w;
  endfunction

  function automatic int tree_rows(input int w);
    return SIGNED_TREE ? w + 2 : w;
  endfunction

  function automatic int rows_at(input int nr, input int lvl);
    int n;
    n = nr;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int tree_levels(input int nr);
    int n, l;
    n = nr;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  // Lowest column that can hold a non-zero bit for a row at a tree level;
  // columns below it are known zero and get half adders or plain wires.
  function automatic int row_lo(input int nr, input int lvl, input int row);
    logic [63:0][7:0] lo, nx;
    int n, t0, t1, t2, m1, mx, m2;
    n = nr;
    for (int r = 0; r < 64; r++) lo[r] = 8'(r);
    for (int k = 0; k < lvl; k++) begin
      nx = '0;
      for (int g = 0; g < 21; g++) begin
        if (g < n / 3) begin
          t0 = int'(lo[3*g]);
          t1 = int'(lo[3*g+1]);
          t2 = int'(lo[3*g+2]);
          m1 = (t0 < t1) ? ((t0 < t2) ? t0 : t2) : ((t1 < t2) ? t1 : t2);
          mx = (t0 > t1) ? ((t0 > t2) ? t0 : t2) : ((t1 > t2) ? t1 : t2);
          m2 = t0 + t1 + t2 - m1 - mx;
          nx[2*g]   = 8'(m1);
          nx[2*g+1] = 8'(m2 + 1);
        end
      end
      for (int t = 0; t < 2; t++)
        if (t < n % 3) nx[2*(n/3)+t] = lo[3*(n/3)+t];
      lo = nx;
      n  = 2 * (n / 3) + n % 3;
    end
    return int'(lo[row]);
  endfunction
endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/HalfAdder.sv
// One-bit half adder cell.
module HalfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace reduction of the partial products to a carry-save pair.
// WALLACE_SIGNED_EN adds Baugh-Wooley sign handling driven by sign.
module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sign,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] cry
);
  localparam int PW = 2 * WIDTH;
  localparam int NB = tree_bits(WIDTH);
  localparam int NR = tree_rows(WIDTH);
  localparam int NL = tree_levels(NR);

  logic [NB-1:0] a, b;
  logic [PW-1:0] rows [NL+1][NR];

`ifdef WALLACE_SIGNED_EN
  assign a = {sign & x[WIDTH-1], x};
  assign b = {sign & y[WIDTH-1], y};
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign a = x;
  assign b = y;
`endif

  // Level 0: partial-product rows, plus the Baugh-Wooley constant row.
  for (genvar j = 0; j < NR; j++) begin : g_pp_row
    for (genvar c = 0; c < PW; c++) begin : g_pp_col
      localparam int I   = c - j;
      localparam bit INV = SIGNED_TREE && ((I == NB - 1) != (j == NB - 1));
      if (j < NB && I >= 0 && I < NB) begin : g_bit
        assign rows[0][j][c] = INV ? ~(a[I] & b[j]) : (a[I] & b[j]);
      end else if (SIGNED_TREE && j == NB && c == NB) begin : g_one
        assign rows[0][j][c] = 1'b1;
      end else begin : g_zero
        assign rows[0][j][c] = 1'b0;
      end
    end
  end

  for (genvar l = 1; l <= NL; l++) begin : g_lvl
    localparam int NP = rows_at(NR, l - 1);
    for (genvar g = 0; g < NP / 3; g++) begin : g_grp
      localparam int LA = row_lo(NR, l - 1, 3 * g);
      localparam int LB = row_lo(NR, l - 1, 3 * g + 1);
      localparam int LC = row_lo(NR, l - 1, 3 * g + 2);
      logic [PW-1:0] s, co;
      logic unused_co;
      for (genvar c = 0; c < PW; c++) begin : g_col
        localparam bit PA = (LA <= c);
        localparam bit PB = (LB <= c);
        localparam bit PC = (LC <= c);
        if (PA && PB && PC) begin : g_fa
          FullAdder u_fa (.a(rows[l-1][3*g][c]), .b(rows[l-1][3*g+1][c]),
                          .ci(rows[l-1][3*g+2][c]), .s(s[c]), .co(co[c]));
        end else if (PA && PB) begin : g_ha_ab
          HalfAdder u_ha (.a(rows[l-1][3*g][c]), .b(rows[l-1][3*g+1][c]),
                          .s(s[c]), .co(co[c]));
        end else if (PA && PC) begin : g_ha_ac
          HalfAdder u_ha (.a(rows[l-1][3*g][c]), .b(rows[l-1][3*g+2][c]),
                          .s(s[c]), .co(co[c]));
        end else if (PB && PC) begin : g_ha_bc
          HalfAdder u_ha (.a(rows[l-1][3*g+1][c]), .b(rows[l-1][3*g+2][c]),
                          .s(s[c]), .co(co[c]));
        end else begin : g_wire
          assign s[c]  = PA ? rows[l-1][3*g][c] :
                         PB ? rows[l-1][3*g+1][c] :
                         PC ? rows[l-1][3*g+2][c] : 1'b0;
          assign co[c] = 1'b0;
        end
      end
      // Carry out of the top column falls outside the 2*WIDTH product.
      assign unused_co       = co[PW-1];
      assign rows[l][2*g]    = s;
      assign rows[l][2*g+1]  = {co[PW-2:0], 1'b0};
    end
    for (genvar t = 0; t < NP % 3; t++) begin : g_pass
      assign rows[l][2*(NP/3)+t] = rows[l-1][3*(NP/3)+t];
    end
  end

  assign sum = rows[NL][0];
  assign cry = rows[NL][1];
endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace multiplier: operand regs, carry-save regs, final adder.
// Signed operands supported only when WALLACE_SIGNED_EN is defined.
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x_in,
  input  logic [WIDTH-1:0]     y_in,
  input  logic                 sign_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result_out
);
  localparam int PW   = 2 * WIDTH;
  localparam int NSTG = latency(OUT_REG);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("wallace_mul_pipe: WIDTH out of range");
  end

  logic              adv;
  logic [NSTG:1]     vld_pipe_d, vld_pipe_q;
  logic [WIDTH-1:0]  x_d, x_q, y_d, y_q;
  logic              sign_d, sign_q;
  logic [PW-1:0]     sum_d, sum_q, cry_d, cry_q;
  logic [PW-1:0]     csa_sum, csa_cry, fin;

  // Whole pipe moves in lockstep; bubbles stay put while stalled.
  assign adv       = rst | ~vld_pipe_q[NSTG] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[NSTG];

  wallace_csa_tree #(.WIDTH(WIDTH)) u_tree (
    .x   (x_q),
    .y   (y_q),
    .sign(sign_q),
    .sum (csa_sum),
    .cry (csa_cry)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    x_d        = x_q;
    y_d        = y_q;
    sign_d     = sign_q;
    sum_d      = sum_q;
    cry_d      = cry_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[NSTG-1:1], in_valid};
      sum_d      = csa_sum;
      cry_d      = csa_cry;
      if (in_valid) begin
        x_d    = x_in;
        y_d    = y_in;
        sign_d = sign_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sign_q     <= 1'b0;
      sum_q      <= '0;
      cry_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sign_q     <= sign_d;
      sum_q      <= sum_d;
      cry_q      <= cry_d;
    end
  end

  assign fin = sum_q + cry_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [PW-1:0] res_d, res_q;
    always_comb begin
      res_d = res_q;
      if (adv) res_d = fin;
    end
    always_ff @(posedge clk) begin
      if (rst) res_q <= '0;
      else     res_q <= res_d;
    end
    assign result_out = res_q;
  end else begin : g_ocomb
    assign result_out = fin;
  end
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed-vector bench for wallace_mul_pipe (WIDTH=12, OUT_REG=1).
module tb_wallace_mul_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] x_in, y_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] result_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        s;
    logic [23:0] exp_u;  // build without signed support
    logic [23:0] exp_s;  // build with signed support
  } vec_t;

  vec_t tv [12];

  wallace_mul_pipe #(.WIDTH(12), .OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_out(result_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_of(input int k);
`ifdef WALLACE_SIGNED_EN
    return tv[k].exp_s;
`else
    return tv[k].exp_u;
`endif
  endfunction

  task automatic drive(input int k);
    x_in     = tv[k].x;
    y_in     = tv[k].y;
    sign_in  = tv[k].s;
    in_valid = 1'b1;
  endtask

  initial begin
    int n_out, first, last, acc, stale;
    logic [23:0] got [$];
    logic        took;

    tv[0]  = '{12'hFFF, 12'hFFF, 1'b0, 24'hFFE001, 24'hFFE001};
    tv[1]  = '{12'h800, 12'h800, 1'b1, 24'h400000, 24'h400000};
    tv[2]  = '{12'hFFF, 12'h001, 1'b1, 24'h000FFF, 24'hFFFFFF};
    tv[3]  = '{12'h000, 12'h123, 1'b0, 24'h000000, 24'h000000};
    tv[4]  = '{12'h123, 12'h456, 1'b0, 24'h04EDC2, 24'h04EDC2};
    tv[5]  = '{12'hFFF, 12'hFFF, 1'b1, 24'hFFE001, 24'h000001};
    tv[6]  = '{12'h7FF, 12'h800, 1'b1, 24'h3FF800, 24'hC00800};
    tv[7]  = '{12'h001, 12'h001, 1'b0, 24'h000001, 24'h000001};
    tv[8]  = '{12'hABC, 12'h00F, 1'b0, 24'h00A104, 24'h00A104};
    tv[9]  = '{12'hFFE, 12'h003, 1'b1, 24'h002FFA, 24'hFFFFFA};
    tv[10] = '{12'h800, 12'h001, 1'b1, 24'h000800, 24'hFFF800};
    tv[11] = '{12'h555, 12'hAAA, 1'b0, 24'h38DC72, 24'h38DC72};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; sign_in = 1'b0;
    tick();
    chk("in_ready_during_rst", in_ready, 1);
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result_out, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency: out_valid rises on the third edge counting the transfer edge.
    drive(0);
    tick();
    in_valid = 1'b0;
    chk("lat_edge1", out_valid, 0);
    tick();
    chk("lat_edge2", out_valid, 0);
    tick();
    chk("lat_edge3", out_valid, 1);
    chk("lat_result", result_out, 24'hFFE001);
    tick();

    for (int k = 0; k < 12; k++) begin
      int w;
      drive(k);
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin
        tick();
        w++;
      end
      chk($sformatf("vec%0d_valid", k), out_valid, 1);
      chk($sformatf("vec%0d_result", k), result_out, exp_of(k));
      tick();
    end

    // Back-to-back stream of 20 operations.
    n_out = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) drive(c % 12);
      else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        chk($sformatf("b2b_res%0d", n_out), result_out, exp_of(n_out % 12));
        if (first < 0) first = c;
        last = c;
        n_out++;
      end
    end
    chk("b2b_count", n_out, 20);
    chk("b2b_span", last - first, 19);

    // Stall: out_ready low, offer 4 operations.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(4 + (acc % 4) * 2);
      took = in_ready;
      tick();
      if (took) acc++;
    end
    chk("stall_accepted", acc, 3);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_result", result_out, exp_of(4));
    tick();
    tick();
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_result", result_out, exp_of(4));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) got.push_back(result_out);
      tick();
    end
    chk("drain_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("drain_0", got[0], exp_of(4));
      chk("drain_1", got[1], exp_of(6));
      chk("drain_2", got[2], exp_of(8));
    end

    // Reset with two operations in flight.
    drive(11);
    tick();
    drive(9);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_result", result_out, 0);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      tick();
    end
    chk("mid_rst_stale", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
